// File: rtl/vbw_pkg.sv
// rtl/vbw_pkg.sv - shared constants and FSM encoding for the arbitrated vbw adder
package vbw_pkg;
    localparam int DW = 64;

    localparam logic [1:0] MODE_64 = 2'b00;
    localparam logic [1:0] MODE_32 = 2'b01;
    localparam logic [1:0] MODE_16 = 2'b10;
    localparam logic [1:0] MODE_8  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with optional lock onto one requester
// Ports: i_req request vector, i_ptr highest-priority index, i_lock/i_lock_id
//        restrict grant to one requester, o_grant one-hot, o_id encoded grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_lock,
    input  logic [IDW-1:0]  i_lock_id,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id
);
    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_idx   = 0;
        if (i_lock) begin
            for (int i = 0; i < NREQ; i++) begin
                if (IDW'(i) == i_lock_id && i_req[i]) begin
                    o_grant[i] = 1'b1;
                    o_id       = i_lock_id;
                end
            end
        end else begin
            // Walk from farthest to nearest so the nearest valid request wins.
            for (int k = NREQ - 1; k >= 0; k--) begin
                w_idx = (int'(i_ptr) + k) % NREQ;
                if (i_req[w_idx]) begin
                    o_grant        = '0;
                    o_grant[w_idx] = 1'b1;
                    o_id           = IDW'(w_idx);
                end
            end
        end
    end
endmodule

// File: rtl/vbw_adder_nci.sv
// rtl/vbw_adder_nci.sv - 64-bit lane-partitioned adder, no carry across lane boundaries
// Ports: i_a/i_b operands, i_ci carry into lane 0, i_mode lane split,
//        o_s sum, o_co carry out of the most significant lane.
module vbw_adder_nci
    import vbw_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_ci,
    input  logic [1:0]    i_mode,
    output logic [DW-1:0] o_s,
    output logic          o_co
);
    logic [8:0] w_byte;
    logic       w_c;
    logic       w_brk;

    // Byte-sliced ripple; the carry chain is cut at every lane boundary.
    always_comb begin
        o_s    = '0;
        w_c    = i_ci;
        w_byte = '0;
        w_brk  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            case (i_mode)
                MODE_8:  w_brk = 1'b1;
                MODE_16: w_brk = (k % 2) == 0;
                MODE_32: w_brk = (k % 4) == 0;
                default: w_brk = 1'b0;
            endcase
            if (k != 0 && w_brk) begin
                w_c = 1'b0;
            end
            w_byte = {1'b0, i_a[8*k +: 8]} + {1'b0, i_b[8*k +: 8]} + {8'd0, w_c};
            o_s[8*k +: 8] = w_byte[7:0];
            w_c = w_byte[8];
        end
        o_co = w_c;
    end
endmodule

// File: rtl/vbw_add_arb.sv
// rtl/vbw_add_arb.sv - round-robin shared vbw adder with carry-chained multi-beat adds
// Ports: clk/rst_n; per-requester req_valid/req_ready/req_a/req_b/req_ci/req_mode/req_chain;
//        registered result rsp_valid/rsp_ready/rsp_id/rsp_s/rsp_co.
module vbw_add_arb
    import vbw_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*64-1:0] req_b,
    input  logic [NREQ-1:0]    req_ci,
    input  logic [NREQ*2-1:0]  req_mode,
    input  logic [NREQ-1:0]    req_chain,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_s,
    output logic               rsp_co
);
    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_ptr, r_lock_id;
    logic            r_carry;
    logic            r_rsp_valid, r_rsp_co;
    logic [IDW-1:0]  r_rsp_id;
    logic [DW-1:0]   r_rsp_s;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gid;
    logic            w_can, w_acc, w_lock;
    logic [DW-1:0]   w_a, w_b, w_s;
    logic [1:0]      w_mode;
    logic            w_ci_in, w_chain, w_ci, w_co;
    logic            w_mode64, w_chain_eff;

    assign w_lock = (r_state == ST_LOCK);
    assign w_can  = !r_rsp_valid || rsp_ready;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .i_lock    (w_lock),
        .i_lock_id (r_lock_id),
        .o_grant   (w_grant),
        .o_id      (w_gid)
    );

    assign req_ready = rst_n ? (w_grant & {NREQ{w_can}}) : '0;
    assign w_acc     = |(req_valid & req_ready);

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_mode  = MODE_64;
        w_ci_in = 1'b0;
        w_chain = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gid) begin
                w_a     = req_a[64*i +: 64];
                w_b     = req_b[64*i +: 64];
                w_mode  = req_mode[2*i +: 2];
                w_ci_in = req_ci[i];
                w_chain = req_chain[i];
            end
        end
    end

    // Only full-width beats may carry into, or out to, another beat.
    assign w_mode64    = (w_mode == MODE_64);
    assign w_chain_eff = w_chain && w_mode64;

    vbw_adder_nci u_add (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_ci   (w_ci),
        .i_mode (w_mode),
        .o_s    (w_s),
        .o_co   (w_co)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_lock_id <= '0;
            r_carry   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                if (w_chain_eff) begin
                    r_lock_id <= w_gid;
                    r_carry   <= w_co;
                end else begin
                    r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
                end
            end
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = w_chain_eff ? ST_LOCK : ST_IDLE;
        end
    end

    // FSM: outputs (carry-in source)
    always_comb begin
        w_ci = 1'b0;
        if (w_mode64) begin
            w_ci = (r_state == ST_LOCK) ? r_carry : w_ci_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_co    <= 1'b0;
            r_rsp_id    <= '0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_s     <= w_s;
            r_rsp_co    <= w_co && w_mode64;
            r_rsp_id    <= w_gid;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_s     = r_rsp_s;
    assign rsp_co    = r_rsp_co;
    assign rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_vbw_add_arb.sv
// tb/tb_vbw_add_arb.sv - randomized and directed bench for vbw_add_arb against a behavioural model
module tb_vbw_add_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready, req_ci, req_chain;
    logic [NREQ*64-1:0] req_a, req_b;
    logic [NREQ*2-1:0]  req_mode;
    logic               rsp_valid, rsp_ready, rsp_co;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_s;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_ptr, m_lid, m_id;
    logic        m_lock, m_carry, m_v, m_co;
    logic [63:0] m_s;

    always #5 clk = ~clk;

    vbw_add_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .req_mode  (req_mode),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane-wise add from first principles: w-bit lanes, carry-in only to lane 0.
    function automatic logic [64:0] ref_add(logic [63:0] a, logic [63:0] b, logic ci, logic [1:0] md);
        int          w;
        logic [64:0] mask, sum, acc;
        logic        co;
        w    = 64 >> md;
        mask = (65'd1 << w) - 65'd1;
        acc  = '0;
        co   = 1'b0;
        for (int j = 0; j < 64 / w; j++) begin
            sum = ((65'(a) >> (j * w)) & mask) + ((65'(b) >> (j * w)) & mask) + 65'((j == 0) ? ci : 1'b0);
            acc = acc | ((sum & mask) << (j * w));
            if (md == 2'b00) co = sum[64];
        end
        return {co, acc[63:0]};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lid = 0; m_id = 0;
        m_lock = 0; m_carry = 0; m_v = 0; m_co = 0; m_s = '0;
    endtask

    // One clock: compare outputs and req_ready on the falling edge, advance model on rising edge.
    task automatic cycle();
        int              g;
        logic            can, ci;
        logic [1:0]      md;
        logic [64:0]     r;
        logic [NREQ-1:0] er;
        @(negedge clk);
        check("rsp_valid", 64'(rsp_valid), 64'(m_v));
        if (m_v) begin
            check("rsp_s", rsp_s, m_s);
            check("rsp_co", 64'(rsp_co), 64'(m_co));
            check("rsp_id", 64'(rsp_id), 64'(m_id));
        end
        g   = -1;
        can = !m_v || rsp_ready;
        if (rst_n) begin
            if (m_lock) begin
                if (req_valid[m_lid]) g = m_lid;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
        end
        er = '0;
        if (g >= 0 && can) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0 && can) begin
            md = req_mode[2*g +: 2];
            if (md != 2'b00) ci = 1'b0;
            else if (m_lock) ci = m_carry;
            else ci = req_ci[g];
            r    = ref_add(req_a[64*g +: 64], req_b[64*g +: 64], ci, md);
            m_v  = 1'b1;
            m_s  = r[63:0];
            m_co = r[64];
            m_id = g;
            if (req_chain[g] && md == 2'b00) begin
                m_lock  = 1'b1;
                m_lid   = g;
                m_carry = r[64];
            end else begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % NREQ;
            end
        end else if (rsp_ready) begin
            m_v = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(int i, logic v, logic [63:0] a, logic [63:0] b, logic ci, logic [1:0] md, logic ch);
        req_valid[i]       = v;
        req_a[64*i +: 64]  = a;
        req_b[64*i +: 64]  = b;
        req_ci[i]          = ci;
        req_mode[2*i +: 2] = md;
        req_chain[i]       = ch;
    endtask

    task automatic clear_req();
        req_valid = '0; req_a = '0; req_b = '0;
        req_ci = '0; req_mode = '0; req_chain = '0;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    logic [63:0] hold_s;
    logic [63:0] ones;

    initial begin
        ones = '1;
        model_reset();
        clear_req();
        rsp_ready = 1'b1;

        // reset with every requester asking
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'(i), 64'd1, 1'b0, 2'b00, 1'b0);
        do_reset(3);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_s", rsp_s, 64'd0);
        cycle();
        check("first_id", 64'(rsp_id), 64'd0);
        check("first_valid", 64'(rsp_valid), 64'd1);

        // lane modes on requester 1
        clear_req();
        set_req(1, 1'b1, 64'hFF, 64'd1, 1'b1, 2'b11, 1'b0);
        cycle();
        check("m8_s", rsp_s, 64'd0);
        check("m8_co", 64'(rsp_co), 64'd0);
        set_req(1, 1'b1, 64'hFF, 64'd1, 1'b1, 2'b00, 1'b0);
        cycle();
        check("m64_s", rsp_s, 64'h101);
        check("m64_co", 64'(rsp_co), 64'd0);
        set_req(1, 1'b1, ones, 64'd1, 1'b1, 2'b01, 1'b0);
        cycle();
        check("m32_s", rsp_s, 64'hFFFF_FFFF_0000_0000);
        check("m32_co", 64'(rsp_co), 64'd0);

        // round robin, all requesters continuously valid
        do_reset(1);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_id", 64'(rsp_id), 64'(k % NREQ));
            check("rr_valid", 64'(rsp_valid), 64'd1);
        end

        // chained 128-bit add on requester 2, requester 0 waits for the lock to end
        do_reset(1);
        clear_req();
        set_req(2, 1'b1, ones, 64'd1, 1'b0, 2'b00, 1'b1);
        cycle();
        check("ch1_s", rsp_s, 64'd0);
        check("ch1_co", 64'(rsp_co), 64'd1);
        check("ch1_id", 64'(rsp_id), 64'd2);
        set_req(2, 1'b1, 64'd0, 64'd0, 1'b0, 2'b00, 1'b0);
        set_req(0, 1'b1, 64'd5, 64'd6, 1'b0, 2'b00, 1'b0);
        cycle();
        check("ch2_s", rsp_s, 64'd1);
        check("ch2_co", 64'(rsp_co), 64'd0);
        check("ch2_id", 64'(rsp_id), 64'd2);
        set_req(2, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b0);
        cycle();
        check("ch3_id", 64'(rsp_id), 64'd0);

        // backpressure
        do_reset(1);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'b00, 1'b0);
        rsp_ready = 1'b0;
        cycle();
        hold_s = rsp_s;
        check("bp_id0", 64'(rsp_id), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_hold_s", rsp_s, hold_s);
            check("bp_hold_id", 64'(rsp_id), 64'd0);
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("bp_resume_id", 64'(rsp_id), 64'(k % NREQ));
        end

        // reset between chained beats discards the stored carry
        do_reset(1);
        clear_req();
        set_req(2, 1'b1, ones, 64'd1, 1'b0, 2'b00, 1'b1);
        cycle();
        check("rc_co", 64'(rsp_co), 64'd1);
        do_reset(1);
        check("rc_valid", 64'(rsp_valid), 64'd0);
        set_req(2, 1'b1, 64'd0, 64'd0, 1'b0, 2'b00, 1'b0);
        cycle();
        check("rc_s", rsp_s, 64'd0);
        check("rc_id", 64'(rsp_id), 64'd2);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, ($urandom_range(0, 9) < 7),
                        ($urandom_range(0, 3) == 0) ? ones : {$urandom, $urandom},
                        ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom},
                        1'($urandom), 2'($urandom), 1'($urandom));
            end
            cycle();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
